// File: rtl/cpu_pkg.sv
// Shared constants, field positions and FSM state type
// for the fetch/decode sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ACC = 4'd2;
  localparam logic [3:0] OP_JMP = 4'd3;
  localparam logic [3:0] OP_ATC = 4'd4;

  localparam logic [2:0] JMP_UNC = 3'd0;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_REG  = 2'd1;
  localparam logic [1:0] T_NUM  = 2'd2;

  localparam int OPC_LSB  = 31;
  localparam int FN_LSB   = 28;
  localparam int SRCT_LSB = 26;
  localparam int SRC_LSB  = 18;
  localparam int DSTT_LSB = 16;
  localparam int DST_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_UOP,
    S_WAIT_CMP
  } state_t;

endpackage

// File: rtl/atc_flag_bank.sv
// Sticky attention flags: pulses set, ATC clears one bit,
// and a set arriving with the clear keeps the flag.
module atc_flag_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] evt,
  input  logic         clr_en,
  input  logic [2:0]   clr_idx,
  output logic [W-1:0] flags
);

  logic [W-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask = W'(1) << clr_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= '0;
    else       flags <= (flags & ~clr_mask) | evt;
  end

endmodule

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode sequencer: drives the program ROM, issues
// MOV/ACC micro-ops and resolves JMP/ATC flow internally.
module cpu_fetch_decode
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IW    = 35,
  parameter int EVT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  input  logic [EVT_W-1:0] evt,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [3:0]      uop_opc,
  output logic [2:0]      uop_fn,
  output logic [1:0]      uop_src_t,
  output logic [1:0]      uop_dst_t,
  output logic [7:0]      uop_src,
  output logic [7:0]      uop_dst,
  output logic            cmp_req,
  input  logic            cmp_valid,
  input  logic            cmp_true,
  output logic [PC_W-1:0] pc,
  output logic [EVT_W-1:0] evt_flags
);

  state_t state, state_next;
  logic [IW-1:0]   ir;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;
  logic [3:0]      f_opc;
  logic [2:0]      f_fn;
  logic [7:0]      f_addr;
  logic            is_uop;
  logic            is_jmp_unc;
  logic            is_jmp_cnd;
  logic            is_atc;
  logic            atc_clr;

  assign f_opc  = ir[OPC_LSB +: 4];
  assign f_fn   = ir[FN_LSB +: 3];
  assign f_addr = ir[ADDR_LSB +: 8];

  assign is_uop     = (f_opc == OP_MOV) || (f_opc == OP_ACC);
  assign is_jmp_unc = (f_opc == OP_JMP) && (f_fn == JMP_UNC);
  assign is_jmp_cnd = (f_opc == OP_JMP) && (f_fn != JMP_UNC);
  assign is_atc     = (f_opc == OP_ATC);

  assign pc_inc = pc + PC_W'(1);
  assign tgt    = PC_W'(f_addr);

  assign rom_addr  = pc;
  assign uop_opc   = f_opc;
  assign uop_fn    = f_fn;
  assign uop_src_t = ir[SRCT_LSB +: 2];
  assign uop_src   = ir[SRC_LSB +: 8];
  assign uop_dst_t = ir[DSTT_LSB +: 2];
  assign uop_dst   = ir[DST_LSB +: 8];

  always_comb begin
    state_next = state;
    pc_next    = pc;
    uop_valid  = 1'b0;
    cmp_req    = 1'b0;
    atc_clr    = 1'b0;
    unique case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        unique case (1'b1)
          is_uop: begin
            uop_valid = 1'b1;
            if (uop_ready) pc_next = pc_inc;
            else           state_next = S_WAIT_UOP;
          end
          is_jmp_unc: pc_next = tgt;
          is_jmp_cnd: begin
            cmp_req = 1'b1;
            if (cmp_valid) pc_next = cmp_true ? tgt : pc_inc;
            else           state_next = S_WAIT_CMP;
          end
          is_atc: begin
            atc_clr = evt_flags[f_fn];
            pc_next = atc_clr ? tgt : pc_inc;
          end
          default: pc_next = pc_inc;
        endcase
      end
      S_WAIT_UOP: begin
        uop_valid = 1'b1;
        if (uop_ready) begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
      end
      S_WAIT_CMP: begin
        cmp_req = 1'b1;
        if (cmp_valid) begin
          pc_next    = cmp_true ? tgt : pc_inc;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH) ir <= rom_data;
    end
  end

  atc_flag_bank #(
    .W(EVT_W)
  ) u_flags (
    .clk    (clk),
    .reset  (reset),
    .evt    (evt),
    .clr_en (atc_clr),
    .clr_idx(f_fn),
    .flags  (evt_flags)
  );

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed bench for cpu_fetch_decode: walks a small ROM
// program covering uop, jump, compare, ATC and reset paths.
module tb_cpu_fetch_decode;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [34:0] rom_data;
  logic [7:0]  evt;
  logic        uop_valid;
  logic        uop_ready;
  logic [3:0]  uop_opc;
  logic [2:0]  uop_fn;
  logic [1:0]  uop_src_t;
  logic [1:0]  uop_dst_t;
  logic [7:0]  uop_src;
  logic [7:0]  uop_dst;
  logic        cmp_req;
  logic        cmp_valid;
  logic        cmp_true;
  logic [7:0]  pc;
  logic [7:0]  evt_flags;

  logic [34:0] rom [256];
  int tests;
  int fails;

  assign rom_data = rom[rom_addr];

  cpu_fetch_decode dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .evt      (evt),
    .uop_valid(uop_valid),
    .uop_ready(uop_ready),
    .uop_opc  (uop_opc),
    .uop_fn   (uop_fn),
    .uop_src_t(uop_src_t),
    .uop_dst_t(uop_dst_t),
    .uop_src  (uop_src),
    .uop_dst  (uop_dst),
    .cmp_req  (cmp_req),
    .cmp_valid(cmp_valid),
    .cmp_true (cmp_true),
    .pc       (pc),
    .evt_flags(evt_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // opc fn src_t src dst_t dst addr at fixed bit positions
  function automatic logic [34:0] ins(
    input logic [3:0] o, input logic [2:0] f,
    input logic [1:0] st, input logic [7:0] s,
    input logic [1:0] dt, input logic [7:0] d,
    input logic [7:0] a);
    return {o, f, st, s, dt, d, a};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    uop_ready = 1'b1;
    cmp_valid = 1'b0;
    cmp_true = 1'b0;
    evt = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (pc !== 8'd0) begin
      fails++; $display("FAIL rst_pc got %0d want 0", pc);
    end
    tests++;
    if (rom_addr !== 8'd0) begin
      fails++; $display("FAIL rst_addr got %0d want 0", rom_addr);
    end
    tests++;
    if ({uop_valid, cmp_req} !== 2'b00) begin
      fails++; $display("FAIL rst_vld got %b want 00", {uop_valid, cmp_req});
    end
    tests++;
    if (evt_flags !== 8'h00) begin
      fails++; $display("FAIL rst_flags got %h want 00", evt_flags);
    end
    tests++;
    if ({uop_opc, uop_fn, uop_src_t, uop_src, uop_dst_t, uop_dst} !== 27'd0) begin
      fails++; $display("FAIL rst_fields got %h want 0", {uop_opc, uop_src, uop_dst});
    end
    reset = 1'b0;
  endtask

  task automatic test_mov;
    tick;
    tests++;
    if (rom_addr !== 8'd0) begin
      fails++; $display("FAIL mov_addr1 got %0d want 0", rom_addr);
    end
    tests++;
    if (uop_valid !== 1'b1) begin
      fails++; $display("FAIL mov_valid got %b want 1", uop_valid);
    end
    tests++;
    if ({uop_opc, uop_src_t, uop_src, uop_dst_t, uop_dst}
        !== {4'd1, 2'd2, 8'd5, 2'd1, 8'd7}) begin
      fails++;
      $display("FAIL mov_fields got opc=%0d st=%0d s=%0d dt=%0d d=%0d want 1 2 5 1 7",
               uop_opc, uop_src_t, uop_src, uop_dst_t, uop_dst);
    end
    tick;
    tests++;
    if (rom_addr !== 8'd1) begin
      fails++; $display("FAIL mov_addr2 got %0d want 1", rom_addr);
    end
    tests++;
    if (uop_valid !== 1'b0) begin
      fails++; $display("FAIL mov_pulse got %b want 0", uop_valid);
    end
  endtask

  task automatic test_jmp;
    tick;
    tests++;
    if ({uop_valid, cmp_req} !== 2'b00) begin
      fails++; $display("FAIL jmp_vld got %b want 00", {uop_valid, cmp_req});
    end
    tick;
    tests++;
    if (pc !== 8'd7) begin
      fails++; $display("FAIL jmp_pc7 got %0d want 7", pc);
    end
    tick;
    tick;
    tests++;
    if (rom_addr !== 8'd10) begin
      fails++; $display("FAIL jmp_pc10 got %0d want 10", rom_addr);
    end
  endtask

  task automatic test_atc_none;
    tick;
    tick;
    tests++;
    if (pc !== 8'd11) begin
      fails++; $display("FAIL atc_none got %0d want 11", pc);
    end
    tick;
    tick;
    tests++;
    if (pc !== 8'd25) begin
      fails++; $display("FAIL jmp_pc25 got %0d want 25", pc);
    end
  endtask

  task automatic test_cmp;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (cmp_req !== 1'b1 || pc !== 8'd25) begin
        fails++;
        $display("FAIL cmp_wait%0d got req=%b pc=%0d want 1 25", i, cmp_req, pc);
      end
    end
    cmp_valid = 1'b1;
    cmp_true = 1'b1;
    tick;
    cmp_valid = 1'b0;
    tests++;
    if (pc !== 8'd40 || cmp_req !== 1'b0) begin
      fails++; $display("FAIL cmp_taken got pc=%0d req=%b want 40 0", pc, cmp_req);
    end
    tick;
    tick;
    cmp_valid = 1'b1;
    cmp_true = 1'b0;
    tick;
    tests++;
    if (cmp_req !== 1'b1) begin
      fails++; $display("FAIL cmp_req_exec got %b want 1", cmp_req);
    end
    tick;
    cmp_valid = 1'b0;
    tests++;
    if (pc !== 8'd26) begin
      fails++; $display("FAIL cmp_fall got %0d want 26", pc);
    end
  endtask

  task automatic test_atc_flags;
    evt = 8'h04;
    tick;
    evt = 8'h00;
    tick;
    tests++;
    if (pc !== 8'd10 || evt_flags !== 8'h04) begin
      fails++; $display("FAIL atc_set got pc=%0d fl=%h want 10 04", pc, evt_flags);
    end
    tick;
    tick;
    tests++;
    if (pc !== 8'd20 || evt_flags !== 8'h00) begin
      fails++; $display("FAIL atc_take got pc=%0d fl=%h want 20 00", pc, evt_flags);
    end
    evt = 8'h24;
    tick;
    evt = 8'h00;
    tick;
    tick;
    evt = 8'h04;
    tick;
    evt = 8'h00;
    tests++;
    if (pc !== 8'd20 || evt_flags !== 8'h24) begin
      fails++; $display("FAIL atc_race got pc=%0d fl=%h want 20 24", pc, evt_flags);
    end
  endtask

  task automatic test_wrap;
    rom[20] = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd255);
    tick;
    tick;
    tests++;
    if (rom_addr !== 8'd255) begin
      fails++; $display("FAIL wrap_255 got %0d want 255", rom_addr);
    end
    tick;
    tick;
    tests++;
    if (rom_addr !== 8'd0 || evt_flags !== 8'h24) begin
      fails++; $display("FAIL wrap_0 got addr=%0d fl=%h want 0 24", rom_addr, evt_flags);
    end
  endtask

  task automatic test_stall;
    uop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 3) uop_ready = 1'b1;
      tests++;
      if (uop_valid !== 1'b1 || uop_src !== 8'd5 || uop_dst !== 8'd7 || pc !== 8'd0) begin
        fails++;
        $display("FAIL stall%0d got v=%b s=%0d d=%0d pc=%0d want 1 5 7 0",
                 i, uop_valid, uop_src, uop_dst, pc);
      end
    end
    tick;
    tests++;
    if (pc !== 8'd1 || uop_valid !== 1'b0) begin
      fails++; $display("FAIL stall_acc got pc=%0d v=%b want 1 0", pc, uop_valid);
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    uop_ready = 1'b0;
    evt = 8'h08;
    tick;
    evt = 8'h00;
    tick;
    tests++;
    if (uop_valid !== 1'b1 || evt_flags !== 8'h08) begin
      fails++; $display("FAIL rmid_pre got v=%b fl=%h want 1 08", uop_valid, evt_flags);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (uop_valid !== 1'b0 || cmp_req !== 1'b0) begin
      fails++; $display("FAIL rmid_drop got v=%b r=%b want 0 0", uop_valid, cmp_req);
    end
    tests++;
    if (evt_flags !== 8'h00 || pc !== 8'd0) begin
      fails++; $display("FAIL rmid_state got fl=%h pc=%0d want 00 0", evt_flags, pc);
    end
    tick;
    reset = 1'b0;
    uop_ready = 1'b1;
    tick;
    tests++;
    if (uop_valid !== 1'b1 || rom_addr !== 8'd0) begin
      fails++; $display("FAIL rmid_restart got v=%b a=%0d want 1 0", uop_valid, rom_addr);
    end
    tick;
    tests++;
    if (pc !== 8'd1) begin
      fails++; $display("FAIL rmid_acc got %0d want 1", pc);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0]  = ins(4'd1, 3'd0, 2'd2, 8'd5, 2'd1, 8'd7, 8'd0);
    rom[1]  = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd7);
    rom[7]  = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd10);
    rom[10] = ins(4'd4, 3'd2, 2'd0, 8'd0, 2'd0, 8'd0, 8'd20);
    rom[11] = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd25);
    rom[25] = ins(4'd3, 3'd1, 2'd1, 8'd3, 2'd1, 8'd4, 8'd40);
    rom[26] = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd10);
    rom[20] = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd10);
    rom[40] = ins(4'd3, 3'd0, 2'd0, 8'd0, 2'd0, 8'd0, 8'd25);
    test_reset;
    test_mov;
    test_jmp;
    test_atc_none;
    test_cmp;
    test_atc_flags;
    test_wrap;
    test_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
